mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/alu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 60 ++++++
 rtl/mdu_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg: shared types for the multiply/divide unit.
//   mdu_op_t    : operation select (MDU_MUL, MDU_DIV)
//   mdu_state_t : controller states (IDLE, RUN, DONE)
//   mdu_cnt_width() : width of the RUN-cycle counter for a given operand width
// ----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic {
      MDU_MUL = 1'b0,
      MDU_DIV = 1'b1
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   // Counter only needs to reach WIDTH-1 (index of the last RUN cycle).
   function automatic int unsigned mdu_cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mdu_step.sv
// ----------------------------------------------------------------------------
// mdu_step: one iteration of the multiply/divide datapath (purely combinational).
//   MUL: acc += mcand when the multiplier LSB is set; mcand shifts left,
//        multiplier shifts right (LSB-first shift-add).
//   DIV: acc holds {remainder, dividend/quotient}; one restoring step shifts the
//        next dividend bit into the remainder and shifts a quotient bit in.
// Ports:
//   op         : operation being iterated
//   acc_in     : accumulator (MUL product / DIV {rem, quo})   -> acc_out
//   mcand_in   : shifted multiplicand (MUL only)               -> mcand_out
//   mplier_in  : remaining multiplier (MUL only)               -> mplier_out
//   divisor_in : divisor (DIV only)
// ----------------------------------------------------------------------------
module mdu_step
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  mdu_op_t              op,
   input  logic [2*WIDTH-1:0]   acc_in,
   input  logic [2*WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]     mplier_in,
   input  logic [WIDTH-1:0]     divisor_in,
   output logic [2*WIDTH-1:0]   acc_out,
   output logic [2*WIDTH-1:0]   mcand_out,
   output logic [WIDTH-1:0]     mplier_out
);

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             fits;

   always_comb begin
      rem     = acc_in[2*WIDTH-1:WIDTH];
      quo     = acc_in[WIDTH-1:0];
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, divisor_in};
      fits    = shifted >= {1'b0, divisor_in};

      acc_out    = acc_in;
      mcand_out  = mcand_in;
      mplier_out = mplier_in;

      unique case (op)
         MDU_MUL: begin
            acc_out    = mplier_in[0] ? (acc_in + mcand_in) : acc_in;
            mcand_out  = mcand_in << 1;
            mplier_out = mplier_in >> 1;
         end
         MDU_DIV: begin
            // When the subtraction does not fit, shifted's top bit is always 0
            // (a set top bit would exceed any WIDTH-bit divisor), so truncation is safe.
            acc_out = {(fits ? WIDTH'(diff) : WIDTH'(shifted)), quo[WIDTH-2:0], fits};
         end
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// ----------------------------------------------------------------------------
// mdu_ctrl: iterative unsigned multiply/divide controller with pipeline stall.
// Optional feature macro: MDU_EARLY_TERM_EN -- ends a multiply as soon as the
// remaining shifted multiplier reaches zero (minimum one RUN cycle).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, op, a, b : request, operation and unsigned operands (taken in IDLE only)
//   stall           : hold upstream stages (RUN, or IDLE with start)
//   busy            : state is not IDLE
//   done            : one-cycle result-valid pulse (DONE state)
//   res_lo, res_hi  : product low/high, or quotient/remainder
//   div_zero        : divide by zero flag, valid with done
// ----------------------------------------------------------------------------
module mdu_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  mdu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             div_zero
);

   localparam int unsigned       CntW    = mdu_cnt_width(WIDTH);
   localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);

   mdu_state_t         state_q, state_d;
   mdu_op_t            op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic               div_zero_q, div_zero_d;

   logic [2*WIDTH-1:0] step_acc;
   logic [2*WIDTH-1:0] step_mcand;
   logic [WIDTH-1:0]   step_mplier;

   logic accept;
   logic zero_div;
   logic run_last;

   assign accept   = (state_q == IDLE) && start;
   assign zero_div = (op == MDU_DIV) && (b == '0);

`ifdef MDU_EARLY_TERM_EN
   // Stop once no multiplier bits remain; divides always run the full WIDTH.
   assign run_last = (cnt_q == CntLast) || ((op_q == MDU_MUL) && (step_mplier == '0));
`else
   assign run_last = (cnt_q == CntLast);
`endif

   mdu_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op         (op_q),
      .acc_in     (acc_q),
      .mcand_in   (mcand_q),
      .mplier_in  (mplier_q),
      .divisor_in (divisor_q),
      .acc_out    (step_acc),
      .mcand_out  (step_mcand),
      .mplier_out (step_mplier)
   );

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = zero_div ? DONE : RUN;
            end
         end
         RUN: begin
            if (run_last) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      stall    = 1'b0;
      if (!rst) begin
         stall = (state_q == RUN) || accept;
      end
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      res_lo   = res_lo_q;
      res_hi   = res_hi_q;
      div_zero = div_zero_q;
   end

   // ------------------------------------------------------------------------
   // Datapath, counter and result registers
   // ------------------------------------------------------------------------
   always_comb begin
      op_d       = op_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      divisor_d  = divisor_q;
      cnt_d      = cnt_q;
      res_lo_d   = res_lo_q;
      res_hi_d   = res_hi_q;
      div_zero_d = div_zero_q;

      if (accept) begin
         op_d       = op;
         // DIV keeps {remainder=0, dividend} in acc; MUL accumulates from zero.
         acc_d      = (op == MDU_DIV) ? {{WIDTH{1'b0}}, a} : '0;
         mcand_d    = {{WIDTH{1'b0}}, a};
         mplier_d   = b;
         divisor_d  = b;
         cnt_d      = '0;
         div_zero_d = 1'b0;
         if (zero_div) begin
            res_lo_d   = '1;
            res_hi_d   = a;
            div_zero_d = 1'b1;
         end
      end else if (state_q == RUN) begin
         acc_d    = step_acc;
         mcand_d  = step_mcand;
         mplier_d = step_mplier;
         cnt_d    = cnt_q + CntW'(1);
         if (run_last) begin
            res_lo_d = step_acc[WIDTH-1:0];
            res_hi_d = step_acc[2*WIDTH-1:WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= MDU_MUL;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         divisor_q  <= '0;
         cnt_q      <= '0;
         res_lo_q   <= '0;
         res_hi_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         op_q       <= op_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         divisor_q  <= divisor_d;
         cnt_q      <= cnt_d;
         res_lo_q   <= res_lo_d;
         res_hi_q   <= res_hi_d;
         div_zero_q <= div_zero_d;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl (WIDTH=16). Expected results,
// latency and stall length are queued when an operation is issued and checked
// when done pulses. Inputs change 1 time unit after posedge; outputs are
// sampled on negedge.
// ----------------------------------------------------------------------------
module tb_mdu_ctrl;
   import alu_pkg::*;

   localparam int unsigned W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   mdu_op_t       op;
   logic [W-1:0]  a, b;
   logic          stall, busy, done, div_zero;
   logic [W-1:0]  res_lo, res_hi;

   mdu_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .res_lo   (res_lo),
      .res_hi   (res_hi),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dz;
      int           lat;
      int           t0;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   stall_cnt = 0;
   int   n_chk = 0;
   int   n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Cycles from the start cycle to the done cycle.
   function automatic int exp_lat(input mdu_op_t o, input logic [W-1:0] y);
      int runs;
      if (o == MDU_DIV) return (y == '0) ? 1 : W + 1;
`ifdef MDU_EARLY_TERM_EN
      runs = 1;
      for (int i = 0; i < W; i++) if (y[i]) runs = i + 1;
      return runs + 1;
`else
      runs = W;
      return runs + 1;
`endif
   endfunction

   // Monitor: count stall cycles of the pending op, check results on done.
   always @(negedge clk) begin
      if (sb_q.size() > 0 && stall) stall_cnt++;
      if (done) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_done", done, 0);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq("res_lo", res_lo, mon_e.lo);
            check_eq("res_hi", res_hi, mon_e.hi);
            check_eq("div_zero", div_zero, mon_e.dz);
            check_eq("latency", cyc - mon_e.t0, mon_e.lat);
            check_eq("stall_len", stall_cnt, mon_e.lat);
            check_eq("stall_in_done", stall, 0);
            check_eq("busy_in_done", busy, 1);
         end
      end
   end

   // Issue one op; optionally pulse a junk start extra_at cycles later.
   task automatic do_op(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int extra_at);
      exp_t             e;
      logic [2*W-1:0]   p;
      @(posedge clk); #1;
      if (o == MDU_MUL) begin
         p    = {{W{1'b0}}, x} * {{W{1'b0}}, y};
         e.lo = p[W-1:0];
         e.hi = p[2*W-1:W];
         e.dz = 1'b0;
      end else if (y == '0) begin
         e.lo = '1;
         e.hi = x;
         e.dz = 1'b1;
      end else begin
         e.lo = x / y;
         e.hi = x % y;
         e.dz = 1'b0;
      end
      e.lat     = exp_lat(o, y);
      e.t0      = cyc;
      stall_cnt = 0;
      sb_q.push_back(e);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (sb_q.size() == 0) break;
         start = (i == extra_at);
         op    = MDU_MUL;
         a     = W'($urandom);
         b     = W'($urandom);
         if (i == 100) begin
            check_eq("timeout", sb_q.size(), 0);
            sb_q.delete();
         end
      end
      start = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = MDU_MUL;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      check_eq("stall_rst_high", stall, 0);
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_res_lo", res_lo, 0);
      check_eq("rst_res_hi", res_hi, 0);
      check_eq("rst_dz", div_zero, 0);

      do_op(MDU_MUL, 16'd3, 16'd5, 0);
      do_op(MDU_MUL, 16'hFFFF, 16'hFFFF, 0);
      do_op(MDU_DIV, 16'd100, 16'd7, 0);
      do_op(MDU_DIV, 16'd42, 16'd0, 0);
      @(negedge clk);
      check_eq("dz_hold", div_zero, 1);
      check_eq("hold_lo", res_lo, 16'hFFFF);
      do_op(MDU_MUL, 16'd1234, 16'd567, 5);        // start ignored in RUN
      do_op(MDU_DIV, 16'd5000, 16'd13, exp_lat(MDU_DIV, 16'd13)); // start in DONE
      do_op(MDU_MUL, 16'd7, 16'd0, 0);
      do_op(MDU_DIV, 16'd3, 16'd9, 0);
      for (int k = 0; k < 6; k++) begin
         do_op(mdu_op_t'($urandom_range(0, 1)), W'($urandom), W'($urandom_range(0, 300)), 0);
      end

      // Reset 8 cycles into a divide.
      @(posedge clk); #1;
      start = 1'b1;
      op    = MDU_DIV;
      a     = 16'd1000;
      b     = 16'd3;
      repeat (8) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check_eq("stall_rst_run", stall, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_stall", stall, 0);
      check_eq("abort_res_lo", res_lo, 0);
      check_eq("abort_res_hi", res_hi, 0);
      check_eq("abort_dz", div_zero, 0);

      // Reset wins over a simultaneous start.
      @(posedge clk); #1;
      rst   = 1'b1;
      start = 1'b1;
      op    = MDU_MUL;
      a     = 16'd5;
      b     = 16'd5;
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_eq("rst_start_busy", busy, 0);

      do_op(MDU_MUL, 16'd2, 16'd2, 0);
      repeat (20) @(posedge clk);
      check_eq("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
